// File: rtl/calc_serial_loader.sv
// Streams one left (f) and one right (g) image into two on-chip pixel stores,
// then serves registered random reads to the disparity calculator until released.
module calc_serial_loader #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          in_ready,
  input  logic [AW-1:0] address_f,
  input  logic [AW-1:0] address_g,
  output logic [PW-1:0] fdata,
  output logic [PW-1:0] gdata,
  output logic          frame_ready,
  input  logic          frame_release,
  output logic [7:0]    frame_count
);

  typedef enum logic [1:0] {
    LOAD_F = 2'd0,
    LOAD_G = 2'd1,
    SERVE  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] wr_addr_reg, wr_addr_next;
  logic          frame_ready_reg, frame_ready_next;
  logic [7:0]    frame_count_reg, frame_count_next;

  logic [PW-1:0] f_mem [DEPTH];
  logic [PW-1:0] g_mem [DEPTH];

  logic accept;
  logic last_pixel;

  assign in_ready    = (state_reg != SERVE);
  assign accept      = in_ready && in_valid;
  assign last_pixel  = (wr_addr_reg == AW'(DEPTH - 1));
  assign frame_ready = frame_ready_reg;
  assign frame_count = frame_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= LOAD_F;
      wr_addr_reg     <= '0;
      frame_ready_reg <= 1'b0;
      frame_count_reg <= 8'd0;
    end else begin
      state_reg       <= state_next;
      wr_addr_reg     <= wr_addr_next;
      frame_ready_reg <= frame_ready_next;
      frame_count_reg <= frame_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    wr_addr_next     = wr_addr_reg;
    frame_ready_next = frame_ready_reg;
    frame_count_next = frame_count_reg;
    case (state_reg)
      LOAD_F: begin
        if (accept) begin
          wr_addr_next = last_pixel ? '0 : wr_addr_reg + AW'(1);
          if (last_pixel) state_next = LOAD_G;
        end
      end
      LOAD_G: begin
        if (accept) begin
          wr_addr_next = last_pixel ? '0 : wr_addr_reg + AW'(1);
          if (last_pixel) begin
            state_next       = SERVE;
            frame_ready_next = 1'b1;
            frame_count_next = frame_count_reg + 8'd1;
          end
        end
      end
      SERVE: begin
        if (frame_release) begin
          state_next       = LOAD_F;
          frame_ready_next = 1'b0;
          wr_addr_next     = '0;
        end
      end
      default: state_next = LOAD_F;
    endcase
  end

  // Storage has no reset so a frame survives reset; writes are held off while reset is low.
  always_ff @(posedge clk) begin
    if (reset && accept && (state_reg == LOAD_F)) f_mem[wr_addr_reg] <= in_data;
    if (reset && accept && (state_reg == LOAD_G)) g_mem[wr_addr_reg] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fdata <= '0;
      gdata <= '0;
    end else if (state_reg == SERVE) begin
      fdata <= f_mem[address_f];
      gdata <= g_mem[address_g];
    end else begin
      fdata <= '0;
      gdata <= '0;
    end
  end

endmodule

// File: tb/tb_calc_serial_loader.sv
// Directed-plus-random bench for calc_serial_loader; a frame-level model predicts
// acceptance, frame completion, stored pixels and read-back data every cycle.
module tb_calc_serial_loader;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;
  localparam int PW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [PW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] address_f;
  logic [AW-1:0] address_g;
  logic [PW-1:0] fdata;
  logic [PW-1:0] gdata;
  logic          frame_ready;
  logic          frame_release;
  logic [7:0]    frame_count;

  int total = 0;
  int bad   = 0;

  // Frame-level model: pixels received so far in this frame, whether a full frame is held.
  logic [PW-1:0] ref_f [DEPTH];
  logic [PW-1:0] ref_g [DEPTH];
  int            n_acc     = 0;
  bit            serving   = 1'b0;
  int            frame_cnt = 0;

  calc_serial_loader #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .address_f     (address_f),
    .address_g     (address_g),
    .fdata         (fdata),
    .gdata         (gdata),
    .frame_ready   (frame_ready),
    .frame_release (frame_release),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare just after it.
  task automatic cycle(input logic v, input logic [PW-1:0] d, input logic rel);
    logic [PW-1:0] exp_f, exp_g;
    in_valid      = v;
    in_data       = d;
    frame_release = rel;
    exp_f = serving ? ref_f[address_f] : '0;
    exp_g = serving ? ref_g[address_g] : '0;
    @(posedge clk);
    if (serving) begin
      if (rel) begin
        serving = 1'b0;
        n_acc   = 0;
      end
    end else if (v) begin
      if (n_acc < DEPTH) ref_f[n_acc] = d;
      else               ref_g[n_acc - DEPTH] = d;
      n_acc++;
      if (n_acc == 2 * DEPTH) begin
        serving   = 1'b1;
        frame_cnt = (frame_cnt + 1) % 256;
      end
    end
    #1;
    check("in_ready", in_ready, !serving);
    check("frame_ready", frame_ready, serving);
    check("frame_count", frame_count, frame_cnt);
    check("fdata", fdata, exp_f);
    check("gdata", gdata, exp_g);
  endtask

  task automatic read_pixel(input logic [AW-1:0] af, input logic [AW-1:0] ag);
    address_f = af;
    address_g = ag;
    cycle(1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fdata"}, fdata, 0);
    check({tag, "_gdata"}, gdata, 0);
    check({tag, "_frame_ready"}, frame_ready, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic apply_reset(input string tag);
    in_valid      = 1'b0;
    frame_release = 1'b0;
    reset         = 1'b0;
    #2;
    serving   = 1'b0;
    n_acc     = 0;
    frame_cnt = 0;
    check_reset_outputs(tag);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs(tag);
    end
    reset = 1'b1;
    $display("step reset(%s) released at %0t", tag, $time);
  endtask

  initial begin
    reset         = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    frame_release = 1'b0;
    address_f     = '0;
    address_g     = '0;
    #1;
    apply_reset("por");

    // Full load with index-derived pixels, then fixed read-back points.
    for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b1, PW'(i % 8), 1'b0);
    check("full_frame_count", frame_count, 1);
    read_pixel(11'd5, 11'd10);
    check("full_f5", fdata, 5);
    check("full_g10", gdata, 2);
    $display("step full_load frame_count=%0d f5=%0d g10=%0d", frame_count, fdata, gdata);

    // Random reads while the source keeps pushing random pixels (must all be refused).
    for (int i = 0; i < 40; i++) begin
      address_f = AW'($urandom_range(DEPTH - 1));
      address_g = AW'($urandom_range(DEPTH - 1));
      cycle(1'($urandom), PW'($urandom), 1'b0);
    end
    for (int i = 0; i < 100; i++) cycle(1'b1, 3'd7, 1'b0);
    read_pixel(11'd0, 11'd7);
    check("bp_f0", fdata, 0);
    check("bp_g7", gdata, 7);
    $display("step backpressure f0=%0d g7=%0d", fdata, gdata);

    // Release with in_valid on the same edge, then a stalling reload of value 3
    // with a release pulse during LOAD_G that must be ignored.
    cycle(1'b1, 3'd5, 1'b1);
    check("rel_frame_ready", frame_ready, 0);
    for (int i = 0; i < 4 * DEPTH; i++) cycle(i % 2 == 1, 3'd3, i == 6001);
    check("reload_frame_count", frame_count, 2);
    read_pixel(11'd100, 11'd2047);
    check("reload_f100", fdata, 3);
    check("reload_g2047", gdata, 3);
    $display("step reload frame_count=%0d f100=%0d", frame_count, fdata);

    // Mid-load reset after 1500 random pixels, then a clean load of value 6.
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 8000 && n_acc < 1500; i++) cycle(1'($urandom), PW'($urandom), 1'b0);
    check("midload_count", n_acc, 1500);
    apply_reset("midload");
    for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b1, 3'd6, 1'b0);
    read_pixel(11'd2047, 11'd0);
    check("after_reset_f2047", fdata, 6);
    check("after_reset_count", frame_count, 1);
    $display("step midload_reset f2047=%0d frame_count=%0d", fdata, frame_count);

    // Random-content frame under a random-valid source, then random read-back.
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 20000 && !serving; i++) cycle(1'($urandom), PW'($urandom), 1'b0);
    check("random_frame_done", frame_ready, 1);
    for (int i = 0; i < 60; i++) begin
      address_f = AW'($urandom_range(DEPTH - 1));
      address_g = AW'($urandom_range(DEPTH - 1));
      cycle(1'b0, '0, 1'b0);
    end
    $display("step random_frame frame_count=%0d", frame_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
